// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU systolic-array front end.
package npu_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned LANES_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit offset of lane `lane` inside a packed vector of `dw`-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned dw, input int unsigned lane);
        return dw * lane;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a full FIFO refuses a push even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned W     = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers activation vectors and feeds them diagonally skewed into the systolic array,
// then flushes the array with zero vectors and reports the tile length.
module act_skew_feeder
    import npu_pkg::*;
#(
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned LANES        = LANES_DEF,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DRAIN_CYCLES = 2 * LANES - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW*LANES-1:0] in_data,
    input  logic                in_last,
    output logic [DW*LANES-1:0] lane_data,
    output logic                pe_en,
    output logic                busy,
    output logic                tile_done,
    output logic [7:0]          tile_vecs
);

    localparam int unsigned VW  = DW * LANES;
    localparam int unsigned FW  = VW + 1;
    localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

    state_t         state;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_rdata;
    logic           push_c;
    logic           pop_c;
    logic           adv_c;
    logic [VW-1:0]  stage_d;
    logic [VW-1:0]  stage_q;
    logic [DCW-1:0] drain_cnt;
    logic [7:0]     vec_cnt;

    assign in_ready = !fifo_full && !rst;
    assign push_c   = in_valid && in_ready;

    sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata ({in_last, in_data}),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop/advance decision and selection of the vector entering the skew stage.
    always_comb begin
        pop_c   = 1'b0;
        adv_c   = 1'b0;
        stage_d = '0;
        if (state == STREAM && !fifo_empty) begin
            pop_c   = 1'b1;
            adv_c   = 1'b1;
            stage_d = fifo_rdata[VW-1:0];
        end else if (state == DRAIN) begin
            adv_c   = 1'b1;
        end
    end

    // Lane j sees the stage register through j extra advance-gated registers.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(DW, j);
        if (j == 0) begin : g_direct
            assign lane_data[LSB +: DW] = stage_q[LSB +: DW];
        end else begin : g_delay
            logic [DW-1:0] dly [0:j-1];

            // Delay line for this lane; holds whenever the array stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        dly[k] <= '0;
                    end
                end else if (adv_c) begin
                    dly[0] <= stage_q[LSB +: DW];
                    for (int k = 1; k < j; k++) begin
                        dly[k] <= dly[k-1];
                    end
                end
            end

            assign lane_data[LSB +: DW] = dly[j-1];
        end
    end

    // Tile sequencer, stage register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage_q   <= '0;
            drain_cnt <= '0;
            vec_cnt   <= '0;
            pe_en     <= 1'b0;
            busy      <= 1'b0;
            tile_done <= 1'b0;
            tile_vecs <= '0;
        end else begin
            pe_en     <= adv_c;
            busy      <= (state != IDLE);
            tile_done <= (state == DONE);
            if (adv_c) begin
                stage_q <= stage_d;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state   <= STREAM;
                        vec_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (pop_c) begin
                        if (vec_cnt != 8'hFF) begin
                            vec_cnt <= vec_cnt + 8'd1;
                        end
                        if (fifo_rdata[VW]) begin
                            state     <= DRAIN;
                            drain_cnt <= DCW'(DRAIN_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DCW'(1);
                    if (drain_cnt == DCW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    tile_vecs <= vec_cnt;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder with hand-computed skewed lane sequences.
module tb_act_skew_feeder;

    localparam int unsigned VW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          in_last;
    logic [VW-1:0] lane_data;
    logic          pe_en;
    logic          busy;
    logic          tile_done;
    logic [7:0]    tile_vecs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    act_skew_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .lane_data (lane_data),
        .pe_en     (pe_en),
        .busy      (busy),
        .tile_done (tile_done),
        .tile_vecs (tile_vecs)
    );

    // Monitor log of advancing cycles and tile completions (sampled 1 time unit after the edge).
    logic [VW-1:0] pe_q [$];
    int            pe_cyc [$];
    logic [7:0]    done_q [$];
    int            done_cyc [$];
    int            cyc = 0;
    logic [VW-1:0] exp_seq [$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (pe_en) begin
            pe_q.push_back(lane_data);
            pe_cyc.push_back(cyc);
        end
        if (tile_done) begin
            done_q.push_back(tile_vecs);
            done_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Present one vector and return just after the edge that accepts it.
    task automatic push(input logic [VW-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_accept", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_q.size() < target && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_q.size()), 32'(target));
        tick();
        tick();
    endtask

    task automatic cmp_pe(input string tag, input int base);
        chk({tag, "_pe_count"}, 32'(pe_q.size() - base), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (base + i < pe_q.size()) begin
                chk($sformatf("%s_pe%0d", tag, i), 32'(pe_q[base + i]), 32'(exp_seq[i]));
            end
        end
    endtask

    task automatic chk_vecs(input string tag, input int idx, input int exp);
        if (done_q.size() > idx) begin
            chk(tag, 32'(done_q[idx]), 32'(exp));
        end else begin
            chk({tag, "_missing"}, 32'(done_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int dbase;
        int n;
        logic [VW-1:0] basic_exp [0:6];

        // Reset state
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_lane_data", 32'(lane_data), 32'd0);
        chk("rst_pe_en", 32'(pe_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        chk("rst_tile_vecs", 32'(tile_vecs), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic two-vector tile, cycle-exact
        basic_exp[0] = 24'h000001;
        basic_exp[1] = 24'h000204;
        basic_exp[2] = 24'h030500;
        basic_exp[3] = 24'h060000;
        basic_exp[4] = 24'h000000;
        basic_exp[5] = 24'h000000;
        basic_exp[6] = 24'h000000;
        dbase = done_q.size();
        push(24'h030201, 1'b0);
        push(24'h060504, 1'b1);
        idle();
        n = 0;
        while (!pe_en && n < 30) begin
            tick();
            n++;
        end
        chk("basic_pe_start", 32'(pe_en), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("basic_lane_c%0d", k + 1), 32'(lane_data), 32'(basic_exp[k]));
            chk($sformatf("basic_pe_c%0d", k + 1), 32'(pe_en), 32'd1);
            chk($sformatf("basic_nodone_c%0d", k + 1), 32'(tile_done), 32'd0);
            tick();
        end
        chk("basic_pe_off", 32'(pe_en), 32'd0);
        chk("basic_tile_done", 32'(tile_done), 32'd1);
        chk("basic_tile_vecs", 32'(tile_vecs), 32'd2);
        chk("basic_busy_at_done", 32'(busy), 32'd1);
        tick();
        chk("basic_busy_low", 32'(busy), 32'd0);
        chk("basic_done_pulse", 32'(tile_done), 32'd0);
        chk_vecs("basic_log_vecs", dbase, 2);
        tick();

        // Single-vector tile
        base  = pe_q.size();
        dbase = done_q.size();
        push(24'hFFFFFF, 1'b1);
        idle();
        wait_done("single_done", dbase + 1);
        exp_seq = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h000000, 24'h000000, 24'h000000};
        cmp_pe("single", base);
        if (pe_q.size() >= base + 6) begin
            chk("single_pe_contig", 32'(pe_cyc[base + 5] - pe_cyc[base]), 32'd5);
            chk("single_done_after_pe", 32'(done_cyc[dbase] - pe_cyc[base + 5]), 32'd1);
        end
        chk_vecs("single_vecs", dbase, 1);

        // Stall mid-tile: gap between the two vectors
        base  = pe_q.size();
        dbase = done_q.size();
        push(24'h090807, 1'b0);
        idle();
        tick();
        tick();
        chk("stall_first_pe", 32'(pe_en), 32'd1);
        tick();
        chk("stall_gap_pe", 32'(pe_en), 32'd0);
        chk("stall_gap_hold", 32'(lane_data), 32'h000007);
        push(24'h010101, 1'b1);
        idle();
        wait_done("stall_done", dbase + 1);
        exp_seq = '{24'h000007, 24'h000801, 24'h090100, 24'h010000,
                    24'h000000, 24'h000000, 24'h000000};
        cmp_pe("stall", base);
        chk_vecs("stall_vecs", dbase, 2);

        // Back-to-back tiles
        base  = pe_q.size();
        dbase = done_q.size();
        push(24'h030201, 1'b1);
        push(24'h060504, 1'b0);
        push(24'h090807, 1'b1);
        idle();
        wait_done("b2b_done", dbase + 2);
        exp_seq = '{24'h000001, 24'h000200, 24'h030000, 24'h000000, 24'h000000, 24'h000000,
                    24'h000004, 24'h000507, 24'h060800, 24'h090000,
                    24'h000000, 24'h000000, 24'h000000};
        cmp_pe("b2b", base);
        chk_vecs("b2b_vecs_a", dbase, 1);
        chk_vecs("b2b_vecs_b", dbase + 1, 2);
        if (pe_q.size() >= base + 7 && done_q.size() >= dbase + 1) begin
            chk("b2b_b_after_a_done", 32'(pe_cyc[base + 6] > done_cyc[dbase]), 32'd1);
        end

        // FIFO fills while the previous tile drains
        base  = pe_q.size();
        dbase = done_q.size();
        push(24'h0000AA, 1'b1);
        push(24'h000011, 1'b0);
        push(24'h000012, 1'b0);
        push(24'h000013, 1'b0);
        push(24'h000014, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push(24'h000015, 1'b0);
        push(24'h000016, 1'b1);
        idle();
        wait_done("full_done", dbase + 2);
        exp_seq = '{24'h0000AA, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
                    24'h000011, 24'h000012, 24'h000013, 24'h000014, 24'h000015, 24'h000016,
                    24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        cmp_pe("full", base);
        chk_vecs("full_vecs_a", dbase, 1);
        chk_vecs("full_vecs_b", dbase + 1, 6);

        // Reset during DRAIN with a queued vector
        push(24'h030201, 1'b1);
        push(24'h060504, 1'b0);
        idle();
        tick();
        tick();
        chk("rstd_busy_before", 32'(busy), 32'd1);
        chk("rstd_pe_before", 32'(pe_en), 32'd1);
        base  = pe_q.size();
        dbase = done_q.size();
        rst = 1'b1;
        #1;
        chk("rstd_in_ready_in_rst", 32'(in_ready), 32'd0);
        tick();
        chk("rstd_lane_data", 32'(lane_data), 32'd0);
        chk("rstd_pe_en", 32'(pe_en), 32'd0);
        chk("rstd_busy", 32'(busy), 32'd0);
        chk("rstd_tile_done", 32'(tile_done), 32'd0);
        chk("rstd_tile_vecs", 32'(tile_vecs), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstd_in_ready_after", 32'(in_ready), 32'd1);
        repeat (15) tick();
        chk("rstd_no_done", 32'(done_q.size() - dbase), 32'd0);
        chk("rstd_fifo_empty", 32'(pe_q.size() - base), 32'd0);
        chk("rstd_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
